// File: rtl/axi4_burst_mem_ctrl.sv
// AXI4 slave with an integrated single-port word array. Serves one FIXED/INCR/WRAP burst at a
// time, with round-robin read/write arbitration and per-beat SLVERR.
module axi4_burst_mem_ctrl #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MEM_DEPTH  = 1024
) (
    input  logic                    ACLK,
    input  logic                    ARESET,
    input  logic [ADDR_WIDTH-1:0]   AWADDR,
    input  logic [7:0]              AWLEN,
    input  logic [2:0]              AWSIZE,
    input  logic [1:0]              AWBURST,
    input  logic                    AWVALID,
    output logic                    AWREADY,
    input  logic [DATA_WIDTH-1:0]   WDATA,
    input  logic [DATA_WIDTH/8-1:0] WSTRB,
    input  logic                    WLAST,
    input  logic                    WVALID,
    output logic                    WREADY,
    output logic [1:0]              BRESP,
    output logic                    BVALID,
    input  logic                    BREADY,
    input  logic [ADDR_WIDTH-1:0]   ARADDR,
    input  logic [7:0]              ARLEN,
    input  logic [2:0]              ARSIZE,
    input  logic [1:0]              ARBURST,
    input  logic                    ARVALID,
    output logic                    ARREADY,
    output logic [DATA_WIDTH-1:0]   RDATA,
    output logic [1:0]              RRESP,
    output logic                    RLAST,
    output logic                    RVALID,
    input  logic                    RREADY
);

    localparam int unsigned BYTES  = DATA_WIDTH / 8;
    localparam int unsigned BSHIFT = $clog2(BYTES);
    localparam int unsigned IDXW   = ADDR_WIDTH - BSHIFT;
    localparam int unsigned MEMAW  = $clog2(MEM_DEPTH);

    localparam logic [IDXW-1:0] DEPTH_IDX   = IDXW'(MEM_DEPTH);
    localparam logic [1:0]      RESP_OKAY   = 2'b00;
    localparam logic [1:0]      RESP_SLVERR = 2'b10;
    localparam logic [1:0]      BURST_FIXED = 2'b00;
    localparam logic [1:0]      BURST_INCR  = 2'b01;
    localparam logic [1:0]      BURST_WRAP  = 2'b10;

    typedef enum logic [1:0] {StIdle, StWrData, StWrResp, StRdData} state_e;

    function automatic logic burst_illegal(input logic [7:0] len, input logic [2:0] size,
                                           input logic [1:0] burst);
        logic wrap_len_ok;
        wrap_len_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
        return (size != 3'(BSHIFT)) || (burst == 2'b11) || ((burst == BURST_WRAP) && !wrap_len_ok);
    endfunction

    function automatic logic out_of_range(input logic [IDXW-1:0] idx);
        return idx >= DEPTH_IDX;
    endfunction

    // WRAP keeps the bits above the (len+1)*BYTES block and wraps the bits below it.
    function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] addr,
                                                        input logic [7:0] len,
                                                        input logic [1:0] burst);
        logic [ADDR_WIDTH-1:0] inc;
        logic [ADDR_WIDTH-1:0] mask;
        logic [ADDR_WIDTH-1:0] res;
        inc  = addr + ADDR_WIDTH'(BYTES);
        mask = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << BSHIFT) - ADDR_WIDTH'(1);
        case (burst)
            BURST_FIXED: res = addr;
            BURST_WRAP:  res = (addr & ~mask) | (inc & mask);
            default:     res = inc;
        endcase
        return res;
    endfunction

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    state_e                state_q, state_d;
    logic                  prio_r_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [7:0]            len_q;
    logic [1:0]            burst_q;
    logic [7:0]            beat_q;
    logic                  berr_q;
    logic                  werr_q;
    logic [1:0]            bresp_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [1:0]            rresp_q;
    logic                  rlast_q;

    logic                  is_idle;
    logic                  grant_w, grant_r;
    logic                  aw_hs, w_hs, ar_hs, r_hs;
    logic                  aw_berr, ar_berr;
    logic [IDXW-1:0]       wr_idx;
    logic                  w_last_beat, w_beat_err, w_en;
    logic [IDXW-1:0]       rd_idx;
    logic                  rd_err;
    logic [DATA_WIDTH-1:0] rd_word;

    assign is_idle = (state_q == StIdle);
    assign grant_w = AWVALID & (~ARVALID | ~prio_r_q);
    assign grant_r = ARVALID & (~AWVALID | prio_r_q);

    assign AWREADY = is_idle & grant_w;
    assign ARREADY = is_idle & grant_r;
    assign WREADY  = (state_q == StWrData);
    assign BVALID  = (state_q == StWrResp);
    assign RVALID  = (state_q == StRdData);
    assign BRESP   = bresp_q;
    assign RDATA   = rdata_q;
    assign RRESP   = rresp_q;
    assign RLAST   = rlast_q;

    assign aw_hs = AWVALID & AWREADY;
    assign w_hs  = WVALID & WREADY;
    assign ar_hs = ARVALID & ARREADY;
    assign r_hs  = RVALID & RREADY;

    assign aw_berr = burst_illegal(AWLEN, AWSIZE, AWBURST);
    assign ar_berr = burst_illegal(ARLEN, ARSIZE, ARBURST);

    assign wr_idx      = addr_q[ADDR_WIDTH-1:BSHIFT];
    assign w_last_beat = (beat_q == len_q);
    assign w_beat_err  = berr_q | out_of_range(wr_idx);
    assign w_en        = w_hs & ~w_beat_err;

    // In IDLE the first read beat comes straight from AR; afterwards addr_q holds the next beat.
    assign rd_idx  = is_idle ? ARADDR[ADDR_WIDTH-1:BSHIFT] : addr_q[ADDR_WIDTH-1:BSHIFT];
    assign rd_err  = (is_idle ? ar_berr : berr_q) | out_of_range(rd_idx);
    assign rd_word = mem[rd_idx[MEMAW-1:0]];

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (aw_hs) begin
                    state_d = StWrData;
                end else if (ar_hs) begin
                    state_d = StRdData;
                end
            end
            StWrData: begin
                if (w_hs && w_last_beat) begin
                    state_d = StWrResp;
                end
            end
            StWrResp: begin
                if (BREADY) begin
                    state_d = StIdle;
                end
            end
            StRdData: begin
                if (RREADY && rlast_q) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            prio_r_q <= 1'b0;
            addr_q   <= '0;
            len_q    <= '0;
            burst_q  <= '0;
            beat_q   <= '0;
            berr_q   <= 1'b0;
            werr_q   <= 1'b0;
            bresp_q  <= RESP_OKAY;
            rdata_q  <= '0;
            rresp_q  <= RESP_OKAY;
            rlast_q  <= 1'b0;
        end else begin
            if (aw_hs) begin
                prio_r_q <= 1'b1;
                addr_q   <= AWADDR;
                len_q    <= AWLEN;
                burst_q  <= aw_berr ? BURST_INCR : AWBURST;
                berr_q   <= aw_berr;
                beat_q   <= '0;
                werr_q   <= 1'b0;
            end
            if (ar_hs) begin
                prio_r_q <= 1'b0;
                addr_q   <= next_addr(ARADDR, ARLEN, ar_berr ? BURST_INCR : ARBURST);
                len_q    <= ARLEN;
                burst_q  <= ar_berr ? BURST_INCR : ARBURST;
                berr_q   <= ar_berr;
                beat_q   <= '0;
                rdata_q  <= rd_err ? '0 : rd_word;
                rresp_q  <= rd_err ? RESP_SLVERR : RESP_OKAY;
                rlast_q  <= (ARLEN == 8'd0);
            end
            if (w_hs) begin
                if (w_last_beat) begin
                    bresp_q <= (werr_q | w_beat_err | ~WLAST) ? RESP_SLVERR : RESP_OKAY;
                end else begin
                    werr_q <= werr_q | w_beat_err | WLAST;
                    addr_q <= next_addr(addr_q, len_q, burst_q);
                    beat_q <= beat_q + 8'd1;
                end
            end
            if (r_hs && !rlast_q) begin
                addr_q  <= next_addr(addr_q, len_q, burst_q);
                beat_q  <= beat_q + 8'd1;
                rlast_q <= ((beat_q + 8'd1) == len_q);
                rdata_q <= rd_err ? '0 : rd_word;
                rresp_q <= rd_err ? RESP_SLVERR : RESP_OKAY;
            end
        end
    end

    // Array is deliberately left out of reset so contents survive it.
    always_ff @(posedge ACLK) begin
        if (w_en) begin
            for (int i = 0; i < int'(BYTES); i++) begin
                if (WSTRB[i]) begin
                    mem[wr_idx[MEMAW-1:0]][i*8 +: 8] <= WDATA[i*8 +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_axi4_burst_mem_ctrl.sv
// Directed bench for axi4_burst_mem_ctrl: bursts, strobes, wrap, range errors, arbitration and
// reset mid-burst, each checked against hand-computed values.
module tb_axi4_burst_mem_ctrl;

    logic        ACLK = 1'b0;
    logic        ARESET;
    logic [31:0] AWADDR;
    logic [7:0]  AWLEN;
    logic [2:0]  AWSIZE;
    logic [1:0]  AWBURST;
    logic        AWVALID;
    logic        AWREADY;
    logic [31:0] WDATA;
    logic [3:0]  WSTRB;
    logic        WLAST;
    logic        WVALID;
    logic        WREADY;
    logic [1:0]  BRESP;
    logic        BVALID;
    logic        BREADY;
    logic [31:0] ARADDR;
    logic [7:0]  ARLEN;
    logic [2:0]  ARSIZE;
    logic [1:0]  ARBURST;
    logic        ARVALID;
    logic        ARREADY;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    logic        RLAST;
    logic        RVALID;
    logic        RREADY;

    axi4_burst_mem_ctrl #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .MEM_DEPTH (1024)
    ) dut (
        .ACLK   (ACLK),
        .ARESET (ARESET),
        .AWADDR (AWADDR),
        .AWLEN  (AWLEN),
        .AWSIZE (AWSIZE),
        .AWBURST(AWBURST),
        .AWVALID(AWVALID),
        .AWREADY(AWREADY),
        .WDATA  (WDATA),
        .WSTRB  (WSTRB),
        .WLAST  (WLAST),
        .WVALID (WVALID),
        .WREADY (WREADY),
        .BRESP  (BRESP),
        .BVALID (BVALID),
        .BREADY (BREADY),
        .ARADDR (ARADDR),
        .ARLEN  (ARLEN),
        .ARSIZE (ARSIZE),
        .ARBURST(ARBURST),
        .ARVALID(ARVALID),
        .ARREADY(ARREADY),
        .RDATA  (RDATA),
        .RRESP  (RRESP),
        .RLAST  (RLAST),
        .RVALID (RVALID),
        .RREADY (RREADY)
    );

    always #5 ACLK = ~ACLK;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] exp_data [16];
    logic [1:0]  exp_resp [16];
    logic [31:0] rd_data  [16];
    logic [1:0]  rd_resp  [16];
    logic        rd_last  [16];
    logic [1:0]  bresp_v;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // All phase tasks start and end on a falling edge; inputs settle #1 before sampling.
    task automatic do_aw(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst);
        int n = 0;
        AWADDR = addr; AWLEN = len; AWSIZE = 3'd2; AWBURST = burst; AWVALID = 1'b1;
        #1;
        while (!AWREADY && n < 50) begin @(negedge ACLK); #1; n++; end
        if (!AWREADY) check_eq("aw_timeout", 32'(AWREADY), 32'd1);
        @(negedge ACLK);
        AWVALID = 1'b0;
    endtask

    task automatic do_w(input logic [7:0] len, input logic [31:0] base, input logic [3:0] strb,
                        input logic bad_last);
        for (int i = 0; i <= int'(len); i++) begin
            int n = 0;
            WDATA = base + 32'(i); WSTRB = strb; WVALID = 1'b1;
            WLAST = bad_last ? (i != int'(len)) : (i == int'(len));
            #1;
            while (!WREADY && n < 50) begin @(negedge ACLK); #1; n++; end
            if (!WREADY) check_eq("w_timeout", 32'(WREADY), 32'd1);
            @(negedge ACLK);
        end
        WVALID = 1'b0; WLAST = 1'b0;
    endtask

    task automatic get_b(output logic [1:0] resp);
        int n = 0;
        BREADY = 1'b1;
        #1;
        while (!BVALID && n < 50) begin @(negedge ACLK); #1; n++; end
        if (!BVALID) check_eq("b_timeout", 32'(BVALID), 32'd1);
        resp = BRESP;
        @(negedge ACLK);
        BREADY = 1'b0;
    endtask

    task automatic axi_write(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                             input logic [31:0] base, input logic [3:0] strb, input logic bad_last,
                             output logic [1:0] resp);
        do_aw(addr, len, burst);
        do_w(len, base, strb, bad_last);
        get_b(resp);
    endtask

    task automatic do_ar(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                         input logic check_lat);
        int n = 0;
        ARADDR = addr; ARLEN = len; ARSIZE = 3'd2; ARBURST = burst; ARVALID = 1'b1;
        #1;
        while (!ARREADY && n < 50) begin @(negedge ACLK); #1; n++; end
        if (!ARREADY) check_eq("ar_timeout", 32'(ARREADY), 32'd1);
        @(negedge ACLK);
        ARVALID = 1'b0;
        #1;
        if (check_lat) check_eq("rvalid_latency", 32'(RVALID), 32'd1);
    endtask

    task automatic get_r(input logic [7:0] len, input logic toggle);
        int beat = 0;
        int n = 0;
        while (beat <= int'(len) && n < 200) begin
            RREADY = toggle ? (n % 2 == 0) : 1'b1;
            #1;
            if (RVALID && RREADY) begin
                rd_data[beat] = RDATA; rd_resp[beat] = RRESP; rd_last[beat] = RLAST;
                beat++;
            end else if (RVALID && toggle) begin
                check_eq($sformatf("r_hold_b%0d", beat), RDATA, exp_data[beat]);
            end
            @(negedge ACLK);
            n++;
        end
        RREADY = 1'b0;
        if (beat <= int'(len)) check_eq("r_timeout", 32'(beat), 32'(len) + 32'd1);
    endtask

    task automatic verify_read(input string tag, input logic [7:0] len);
        for (int i = 0; i <= int'(len); i++) begin
            check_eq($sformatf("%s_data%0d", tag, i), rd_data[i], exp_data[i]);
            check_eq($sformatf("%s_resp%0d", tag, i), 32'(rd_resp[i]), 32'(exp_resp[i]));
            check_eq($sformatf("%s_last%0d", tag, i), 32'(rd_last[i]), 32'(i == int'(len)));
        end
    endtask

    task automatic set_exp(input int idx, input logic [31:0] d, input logic [1:0] r);
        exp_data[idx] = d;
        exp_resp[idx] = r;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        ARESET = 1'b1;
        AWADDR = '0; AWLEN = '0; AWSIZE = 3'd2; AWBURST = 2'b01; AWVALID = 1'b0;
        WDATA = '0; WSTRB = '0; WLAST = 1'b0; WVALID = 1'b0; BREADY = 1'b0;
        ARADDR = '0; ARLEN = '0; ARSIZE = 3'd2; ARBURST = 2'b01; ARVALID = 1'b0; RREADY = 1'b0;
        repeat (3) @(negedge ACLK);
        #1;
        check_eq("rst_rvalid", 32'(RVALID), 32'd0);
        check_eq("rst_bvalid", 32'(BVALID), 32'd0);
        check_eq("rst_wready", 32'(WREADY), 32'd0);
        check_eq("rst_rdata", RDATA, 32'd0);
        check_eq("rst_rlast", 32'(RLAST), 32'd0);
        check_eq("rst_bresp", 32'(BRESP), 32'd0);
        check_eq("rst_rresp", 32'(RRESP), 32'd0);
        @(negedge ACLK);
        ARESET = 1'b0;
        @(negedge ACLK);

        // INCR write/read of four beats
        axi_write(32'h10, 8'd3, 2'b01, 32'hA0, 4'hF, 1'b0, bresp_v);
        check_eq("incr_bresp", 32'(bresp_v), 32'd0);
        for (int i = 0; i < 4; i++) set_exp(i, 32'hA0 + 32'(i), 2'b00);
        do_ar(32'h10, 8'd3, 2'b01, 1'b1);
        get_r(8'd3, 1'b0);
        verify_read("incr", 8'd3);

        // Byte strobes
        axi_write(32'h40, 8'd0, 2'b01, 32'hFFFF_FFFF, 4'hF, 1'b0, bresp_v);
        axi_write(32'h40, 8'd0, 2'b01, 32'h0, 4'b0101, 1'b0, bresp_v);
        check_eq("strb_bresp", 32'(bresp_v), 32'd0);
        set_exp(0, 32'hFF00_FF00, 2'b00);
        do_ar(32'h40, 8'd0, 2'b01, 1'b0);
        get_r(8'd0, 1'b0);
        verify_read("strb", 8'd0);

        // WRAP: legal 4-beat, illegal 3-beat
        axi_write(32'h30, 8'd3, 2'b01, 32'hC0, 4'hF, 1'b0, bresp_v);
        set_exp(0, 32'hC2, 2'b00); set_exp(1, 32'hC3, 2'b00);
        set_exp(2, 32'hC0, 2'b00); set_exp(3, 32'hC1, 2'b00);
        do_ar(32'h38, 8'd3, 2'b10, 1'b0);
        get_r(8'd3, 1'b0);
        verify_read("wrap4", 8'd3);
        for (int i = 0; i < 3; i++) set_exp(i, 32'h0, 2'b10);
        do_ar(32'h30, 8'd2, 2'b10, 1'b0);
        get_r(8'd2, 1'b0);
        verify_read("wrap3", 8'd2);

        // Out-of-range tail of a burst; words 0/1 guard against index wraparound
        axi_write(32'h0, 8'd1, 2'b01, 32'h5A5A_5A5A, 4'hF, 1'b0, bresp_v);
        axi_write(32'hFF8, 8'd3, 2'b01, 32'hB0, 4'hF, 1'b0, bresp_v);
        check_eq("oor_bresp", 32'(bresp_v), 32'd2);
        set_exp(0, 32'hB0, 2'b00); set_exp(1, 32'hB1, 2'b00);
        set_exp(2, 32'h0, 2'b10);  set_exp(3, 32'h0, 2'b10);
        do_ar(32'hFF8, 8'd3, 2'b01, 1'b0);
        get_r(8'd3, 1'b0);
        verify_read("oor", 8'd3);
        set_exp(0, 32'h5A5A_5A5A, 2'b00); set_exp(1, 32'h5A5A_5A5B, 2'b00);
        do_ar(32'h0, 8'd1, 2'b01, 1'b0);
        get_r(8'd1, 1'b0);
        verify_read("nowrap", 8'd1);

        // WLAST early on beat 0 and missing on the final beat
        axi_write(32'h60, 8'd1, 2'b01, 32'h70, 4'hF, 1'b1, bresp_v);
        check_eq("wlast_bresp", 32'(bresp_v), 32'd2);
        set_exp(0, 32'h70, 2'b00); set_exp(1, 32'h71, 2'b00);
        do_ar(32'h60, 8'd1, 2'b01, 1'b0);
        get_r(8'd1, 1'b0);
        verify_read("wlast", 8'd1);

        // Simultaneous AW/AR twice: write then read; RREADY toggling
        AWADDR = 32'h80; AWLEN = 8'd0; AWSIZE = 3'd2; AWBURST = 2'b01; AWVALID = 1'b1;
        ARADDR = 32'h10; ARLEN = 8'd3; ARSIZE = 3'd2; ARBURST = 2'b01; ARVALID = 1'b1;
        #1;
        check_eq("arb1_awready", 32'(AWREADY), 32'd1);
        check_eq("arb1_arready", 32'(ARREADY), 32'd0);
        @(negedge ACLK);
        AWVALID = 1'b0;
        do_w(8'd0, 32'h1234_5678, 4'hF, 1'b0);
        get_b(bresp_v);
        check_eq("arb1_bresp", 32'(bresp_v), 32'd0);
        AWVALID = 1'b1;
        #1;
        check_eq("arb2_arready", 32'(ARREADY), 32'd1);
        check_eq("arb2_awready", 32'(AWREADY), 32'd0);
        @(negedge ACLK);
        ARVALID = 1'b0;
        for (int i = 0; i < 4; i++) set_exp(i, 32'hA0 + 32'(i), 2'b00);
        get_r(8'd3, 1'b1);
        verify_read("arb_rd", 8'd3);
        do_aw(32'h80, 8'd0, 2'b01);
        do_w(8'd0, 32'h8765_4321, 4'hF, 1'b0);
        get_b(bresp_v);
        set_exp(0, 32'h8765_4321, 2'b00);
        do_ar(32'h80, 8'd0, 2'b01, 1'b0);
        get_r(8'd0, 1'b0);
        verify_read("arb_wr", 8'd0);

        // Reset while beat 2 of 8 is presented
        do_ar(32'h10, 8'd7, 2'b01, 1'b0);
        RREADY = 1'b1;
        @(negedge ACLK);
        #1;
        check_eq("rst_mid_beat2", RDATA, 32'hA1);
        RREADY = 1'b0;
        ARESET = 1'b1;
        ARADDR = 32'h40; ARLEN = 8'd0; ARVALID = 1'b1;
        #1;
        check_eq("rst_mid_rvalid_async", 32'(RVALID), 32'd0);
        @(negedge ACLK);
        ARESET = 1'b0;
        #1;
        check_eq("rst_mid_rvalid", 32'(RVALID), 32'd0);
        check_eq("rst_mid_arready", 32'(ARREADY), 32'd1);
        set_exp(0, 32'hFF00_FF00, 2'b00);
        do_ar(32'h40, 8'd0, 2'b01, 1'b1);
        get_r(8'd0, 1'b0);
        verify_read("post_rst", 8'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
